// File: rtl/wm_embed_pipe.sv
// Two-stage streaming watermark embedder: a keyed LFSR supplies per-pixel LSB
// patterns that are replaced or XORed into each pixel, with valid/ready on both sides.
module wm_embed_pipe #(
  parameter int                PIX_W   = 8,
  parameter int                NUM_PIX = 4,
  parameter int                WM_BITS = 2,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_PIX*PIX_W-1:0] s_data,
  input  logic                     s_last,
  input  logic [1:0]               s_mode,
  input  logic                     key_load,
  input  logic [LFSR_W-1:0]        key,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NUM_PIX*PIX_W-1:0] m_data,
  output logic                     m_last,
  output logic [15:0]              frame_cnt
);

  localparam int DATA_W = NUM_PIX * PIX_W;
  localparam int WM_W   = NUM_PIX * WM_BITS;

  localparam logic [PIX_W:0]   ONE_SHIFT_C = (PIX_W+1)'(1) << WM_BITS;
  localparam logic [PIX_W-1:0] LSB_MASK_C  = PIX_W'(ONE_SHIFT_C - (PIX_W+1)'(1));

  localparam logic [1:0] MODE_REPLACE_C = 2'd1;
  localparam logic [1:0] MODE_XOR_C     = 2'd2;

  function automatic logic [LFSR_W-1:0] lfsr_step_f(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & TAPS)};
  endfunction

  // Per-pixel embedding; each pixel is handled in isolation so no carry crosses pixels.
  function automatic logic [DATA_W-1:0] embed_f(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        mode,
    input logic [WM_W-1:0]   wm
  );
    logic [DATA_W-1:0] res;
    logic [PIX_W-1:0]  pix;
    logic [PIX_W-1:0]  wext;
    res = data;
    for (int i = 0; i < NUM_PIX; i++) begin
      pix  = data[i*PIX_W +: PIX_W];
      wext = PIX_W'(wm[i*WM_BITS +: WM_BITS]);
      case (mode)
        MODE_REPLACE_C: res[i*PIX_W +: PIX_W] = (pix & ~LSB_MASK_C) | wext;
        MODE_XOR_C:     res[i*PIX_W +: PIX_W] = pix ^ wext;
        default:        res[i*PIX_W +: PIX_W] = pix;
      endcase
    end
    return res;
  endfunction

  logic [LFSR_W-1:0] key_q,       key_d;
  logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
  logic              s1_valid_q,  s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,   s1_data_d;
  logic [1:0]        s1_mode_q,   s1_mode_d;
  logic              s1_last_q,   s1_last_d;
  logic [WM_W-1:0]   s1_wm_q,     s1_wm_d;
  logic              m_valid_q,   m_valid_d;
  logic [DATA_W-1:0] m_data_q,    m_data_d;
  logic              m_last_q,    m_last_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              s1_load_s;
  logic              s2_load_s;
  logic              s_ready_s;

  // Handshake decode; s_ready only looks at pipeline state and m_ready.
  always_comb begin
    s2_load_s = s1_valid_q && (!m_valid_q || m_ready);
    s_ready_s = !s1_valid_q || s2_load_s;
    s1_load_s = s_valid && s_ready_s;
  end

  // Key register and LFSR; a frame's last beat reloads the (possibly just-written) key.
  always_comb begin
    key_d  = key_q;
    lfsr_d = lfsr_q;
    if (key_load) begin
      key_d = key;
    end else begin
      key_d = key_q;
    end
    if (s1_load_s) begin
      if (s_last) begin
        lfsr_d = key_d;
      end else begin
        lfsr_d = lfsr_step_f(lfsr_q);
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Stage 1 capture of the accepted beat together with its watermark slice.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    s1_wm_d    = s1_wm_q;
    if (s1_load_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = s_data;
      s1_mode_d  = s_mode;
      s1_last_d  = s_last;
      s1_wm_d    = lfsr_q[WM_W-1:0];
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 output register; holds while the consumer stalls.
  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;
    if (s2_load_s) begin
      m_valid_d = 1'b1;
      m_data_d  = embed_f(s1_data_q, s1_mode_q, s1_wm_q);
      m_last_d  = s1_last_q;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    if (m_valid_q && m_ready && m_last_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= SEED;
      lfsr_q      <= SEED;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= 2'd0;
      s1_last_q   <= 1'b0;
      s1_wm_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      key_q       <= key_d;
      lfsr_q      <= lfsr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_wm_q     <= s1_wm_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = s_ready_s;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_wm_embed_pipe.sv
// Scoreboard bench for wm_embed_pipe: the driver pushes expected beats, a negedge
// monitor pops and compares on every output handshake.
module tb_wm_embed_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_mode;
  logic        key_load;
  logic [15:0] key;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  wm_embed_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_mode(s_mode),
    .key_load(key_load), .key(key),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mdl_lfsr = 16'hACE1;
  logic [15:0] mdl_key  = 16'hACE1;
  logic [31:0] hold_data;
  int          waits;

  function automatic logic [31:0] ref_embed(input logic [31:0] d, input logic [1:0] mode,
                                            input logic [7:0] wm);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      case (mode)
        2'd1:    r[i*8 +: 2] = wm[i*2 +: 2];
        2'd2:    r[i*8 +: 2] = d[i*8 +: 2] ^ wm[i*2 +: 2];
        default: r[i*8 +: 2] = d[i*8 +: 2];
      endcase
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one beat; expected value is either hand-given or from the reference model.
  task automatic send(input logic [31:0] d, input logic [1:0] mode, input logic last,
                      input bit use_hand, input logic [31:0] hand, output int nwait);
    exp_t e;
    s_data  = d;
    s_mode  = mode;
    s_last  = last;
    s_valid = 1'b1;
    nwait   = 0;
    @(negedge clk);
    while (!s_ready && nwait < 100) begin
      nwait++;
      @(negedge clk);
    end
    if (!s_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: s_ready stuck at %b expected 1", s_ready);
    end else begin
      e.data = use_hand ? hand : ref_embed(d, mode, mdl_lfsr[7:0]);
      e.last = last;
      sb_q.push_back(e);
      mdl_lfsr = last ? mdl_key : ref_step(mdl_lfsr);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic key_pulse(input logic [15:0] k);
    key      = k;
    key_load = 1'b1;
    mdl_key  = k;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected none", m_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("m_data", m_data, mon_e.data);
        check("m_last", {31'd0, m_last}, {31'd0, mon_e.last});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0; s_mode = 2'd0;
    key_load = 1'b0; key = 16'd0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_s_ready",   {31'd0, s_ready}, 32'd1);
    check("rst_m_valid",   {31'd0, m_valid}, 32'd0);
    check("rst_m_data",    m_data, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Single beat from seed, closes frame 1.
    send(32'hFFFFFFFF, 2'd1, 1'b1, 1'b1, 32'hFFFEFCFD, waits);
    drain();
    check("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);

    // Back-to-back XOR then replace, no stall on the input side.
    send(32'h00000000, 2'd2, 1'b0, 1'b1, 32'h03020001, waits);
    check("b2b_wait0", waits, 0);
    send(32'h00000000, 2'd1, 1'b1, 1'b1, 32'h03000003, waits);
    check("b2b_wait1", waits, 0);
    drain();
    check("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);

    // Two identical 3-beat frames: same watermark sequence each time.
    for (int f = 0; f < 2; f++) begin
      send(32'h12345678, 2'd1, 1'b0, 1'b0, 32'd0, waits);
      send(32'hA5A5A5A5, 2'd2, 1'b0, 1'b0, 32'd0, waits);
      send(32'h0F0F0F0F, 2'd3, 1'b1, 1'b0, 32'd0, waits);
    end
    drain();
    check("frame_cnt_4", {16'd0, frame_cnt}, 32'd4);

    // Key change mid-frame: current frame keeps the seed sequence.
    send(32'h00000000, 2'd1, 1'b0, 1'b1, 32'h03020001, waits);
    key_pulse(16'h1234);
    send(32'h00000000, 2'd1, 1'b0, 1'b1, 32'h03000003, waits);
    send(32'h55555555, 2'd2, 1'b1, 1'b0, 32'd0, waits);
    send(32'h00000000, 2'd1, 1'b1, 1'b1, 32'h00030100, waits);
    drain();
    check("frame_cnt_6", {16'd0, frame_cnt}, 32'd6);

    // Backpressure: stall the consumer while streaming six beats.
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(32'h11111111 * (i + 1), 2'(i % 3), (i == 5), 1'b0, 32'd0, waits);
        end
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
        check("bp_m_valid",     {31'd0, m_valid}, 32'd1);
        hold_data = m_data;
        repeat (2) @(negedge clk);
        check("bp_m_data_hold", m_data, hold_data);
        check("bp_s_ready_still_low", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
    check("frame_cnt_7", {16'd0, frame_cnt}, 32'd7);

    // Reset with both stages full discards in-flight beats.
    m_ready = 1'b0;
    send(32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 32'd0, waits);
    send(32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 32'd0, waits);
    check("full_m_valid", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid",   {31'd0, m_valid}, 32'd0);
    check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    sb_q.delete();
    mdl_lfsr = 16'hACE1;
    mdl_key  = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    send(32'hFFFFFFFF, 2'd1, 1'b1, 1'b1, 32'hFFFEFCFD, waits);
    drain();
    check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
